prod_accumulator: RTL
=====================

// Module: prod_accumulator
// PURPOSE
//  Downstream consumer of the 9x9 unsigned multiplier's 17-bit product stream.
//  Sums a burst of products, framed by in_last, into a wider accumulator and
//  presents the total, a beat count and an overflow flag on a valid/ready port.
//  Accepts one product per cycle. Holds the result until the sink accepts it.
// PARAMETERS
//  PROD_W  17  width of incoming unsigned product
//  ACC_W   24  accumulator/result width (must be >= PROD_W)
//  CNT_W   8   beat-counter width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, asynchronous assert, active-low
//  clr        in   1       synchronous abort/clear, highest priority after rst_n
//  in_valid   in   1       product beat valid
//  in_ready   out  1       block can take a beat
//  in_prod    in   PROD_W  unsigned product
//  in_last    in   1       beat is the final beat of the burst
//  out_valid  out  1       result valid
//  out_ready  in   1       sink accepts result
//  out_sum    out  ACC_W   sum of the burst, modulo 2^ACC_W
//  out_count  out  CNT_W   beats in the burst, saturating at 2^CNT_W-1
//  out_ovf    out  1       sticky: sum carried out of ACC_W during this burst
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous) does the following:
//   - state=IDLE; acc, cnt and ovf are cleared
//   - out_valid=0, out_sum=0, out_count=0, out_ovf=0
//  States: IDLE (no beats yet), ACC (burst in progress), DONE (result held).
//  in_ready = (state!=DONE) && !clr. This is combinational from state and clr.
//  Accept = in_valid && in_ready:
//   - acc <= acc + zero-extend(in_prod), wrapping modulo 2^ACC_W
//   - ovf <= ovf | carry-out
//   - cnt <= cnt+1, saturating at all-ones
//  IDLE -> ACC on accept with in_last=0. IDLE/ACC -> DONE on accept with in_last=1.
//  Single-beat burst: IDLE -> DONE directly.
//  DONE: out_valid=1. out_sum, out_count and out_ovf are registered and include
//  the last beat. Latency: out_valid rises on the cycle after the last beat.
//  DONE -> IDLE on out_valid && out_ready. acc, cnt and ovf clear on that edge.
//  out_valid drops the next cycle.
//  Outputs remain stable while out_valid=1 && out_ready=0.
//  No input is taken in DONE, so an output handshake and an input beat never
//  occur in the same cycle.
//  in_valid=0 in ACC: hold state and acc. There is no timeout.
//  clr=1: next state is IDLE. acc, cnt, ovf and out_valid clear.
//   - a beat presented in the same cycle is not accepted (in_ready=0)
//   - a pending DONE result is discarded
//  rst_n asserted mid-burst or in DONE: the partial sum is lost immediately.
//  out_sum, out_count and out_ovf read 0 whenever out_valid=0.
// STRUCTURE
//  Shared package prod_acc_pkg holds:
//   - state enum {IDLE, ACC, DONE}
//   - default widths PROD_W, ACC_W, CNT_W
//  One flat module: FSM plus adder/counter datapath. No sub-module is needed.
//  The sole candidate is sat_counter (saturating beat counter). Instantiate it
//  only if another block already needs it.
// TESTING
//  1. 4-beat burst: products 1,2,3,4 with last on the 4th, out_ready=1
//     -> out_valid 1 cycle later; sum=10, count=4, ovf=0; then IDLE.
//  2. Single beat 0x1FFFF with in_last=1
//     -> sum=131071, count=1; in_ready=0 for exactly 1 cycle (DONE).
//  3. ACC_W=17; beats 0x1FFFF and 0x00002 with last
//     -> sum=1 (wrapped), ovf=1. The next burst starts with ovf=0.
//  4. Result with out_ready=0 for 5 cycles, in_valid held high
//     -> outputs stable, in_ready=0, no beat absorbed; accepted when out_ready=1.
//  5. clr after 2 of 3 beats (values 7,8), then a new burst of 5 with last
//     -> result sum=5, count=1.
//  6. rst_n pulsed low mid-burst, async, between clock edges
//     -> all outputs 0 and in_ready=1 immediately after release.
//  7. CNT_W=2; a 6-beat burst -> out_count=3 (saturated), sum is still correct.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PROD_W_DEF = 17;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/prod_accumulator.sv
// Sums a framed burst of unsigned products and holds total, beat count and
// sticky overflow on a valid/ready result port until the sink takes it.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] in_prod_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_sum_o,
  output logic [CNT_W-1:0]  out_count_o,
  output logic              out_ovf_o
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W:0]     sum_ext;

  assign in_ready_o = (state_q != DONE) && !clr_i;
  assign accept     = in_valid_i && in_ready_o;
  // One extra bit on the adder exposes the carry-out for the sticky flag.
  assign sum_ext    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod_i};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_d   = sum_ext[ACC_W-1:0];
            ovf_d   = ovf_q | sum_ext[ACC_W];
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = in_last_i ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields are masked so the port reads zero outside DONE.
  assign out_valid_o = (state_q == DONE);
  assign out_sum_o   = out_valid_o ? acc_q : '0;
  assign out_count_o = out_valid_o ? cnt_q : '0;
  assign out_ovf_o   = out_valid_o & ovf_q;

endmodule
